// File: rtl/intf_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// intf_sched_pkg: shared types and sizing helpers for the resource scheduler.
// Rev 1.0
// ---------------------------------------------------------------------------
package intf_sched_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 8;
  localparam int LAT_DEF       = 2;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } fsm_e;

  // Like $clog2 but never returns 0, so a single-entry index still has a bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/intf_tag_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// intf_tag_pipe: LAT-deep valid+owner shift register tracking in-flight issues.
// Rev 1.0
// ---------------------------------------------------------------------------
module intf_tag_pipe #(
  parameter int LAT = 2,
  parameter int TW  = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [TW-1:0] in_owner,
  output logic          last_valid,
  output logic [TW-1:0] last_owner
);

  logic [LAT-1:0]         valid_q, valid_d;
  logic [LAT-1:0][TW-1:0] owner_q, owner_d;

  always_comb begin
    valid_d    = valid_q;
    owner_d    = owner_q;
    valid_d[0] = in_valid;
    owner_d[0] = in_owner;
    for (int s = 1; s < LAT; s++) begin
      valid_d[s] = valid_q[s-1];
      owner_d[s] = owner_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign last_valid = valid_q[LAT-1];
  assign last_owner = owner_q[LAT-1];

endmodule
`default_nettype wire

// File: rtl/intf_rr_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// intf_rr_sched: round-robin sharing of one fixed-latency x/y -> xtwo resource.
// Rev 1.0
// ---------------------------------------------------------------------------
module intf_rr_sched
  import intf_sched_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int LAT       = LAT_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*DW-1:0] req_x,
  input  logic [NREQ*DW-1:0] req_y,
  output logic [NREQ-1:0]    req_ready,
  output logic               rs_valid,
  output logic [DW-1:0]      rs_x,
  output logic [DW-1:0]      rs_y,
  input  logic               rs_xtwo_valid,
  input  logic [DW:0]        rs_xtwo,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW:0]        rsp_xtwo,
  output logic               err_orphan
);

  localparam int TW = clog2_min1(NREQ);
  localparam int CW = clog2_min1(MAX_BURST + 1);

  function automatic logic [TW-1:0] wrap_add(input logic [TW-1:0] a, input int k);
    return TW'((int'(a) + k) % NREQ);
  endfunction

  fsm_e            state_q, state_d;
  logic [TW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rs_valid_q, rs_valid_d;
  logic [DW-1:0]   rs_x_q, rs_x_d;
  logic [DW-1:0]   rs_y_q, rs_y_d;
  logic [TW-1:0]   rs_owner_q, rs_owner_d;
  logic            err_orphan_q, err_orphan_d;

  logic            owner_hold;
  logic [TW-1:0]   start;
  logic            gnt_found;
  logic [TW-1:0]   gnt_idx;
  logic            last_valid;
  logic [TW-1:0]   last_owner;
  logic            rsp_hit;

  // While LOCKED, rr_ptr_q is the owner; losing hold rotates the search past it.
  always_comb begin
    owner_hold = (state_q == LOCKED) && req_valid[rr_ptr_q] && req_lock[rr_ptr_q];
    start      = ((state_q == LOCKED) && !owner_hold) ? wrap_add(rr_ptr_q, 1) : rr_ptr_q;
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(start, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_add(start, k);
      end
    end
  end

  assign req_ready = (reset_n && gnt_found) ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    rs_valid_d   = gnt_found;
    rs_x_d       = rs_x_q;
    rs_y_d       = rs_y_q;
    rs_owner_d   = rs_owner_q;
    err_orphan_d = err_orphan_q | (rs_xtwo_valid ^ last_valid);

    if (gnt_found) begin
      rs_x_d     = req_x[int'(gnt_idx)*DW +: DW];
      rs_y_d     = req_y[int'(gnt_idx)*DW +: DW];
      rs_owner_d = gnt_idx;
    end

    if (!gnt_found) begin
      if (state_q == LOCKED) begin
        state_d  = ARB;
        rr_ptr_d = wrap_add(rr_ptr_q, 1);
        cnt_d    = '0;
      end
    end else if ((state_q == LOCKED) && (gnt_idx == rr_ptr_q)) begin
      if (owner_hold && (int'(cnt_q) + 1 < MAX_BURST)) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        state_d  = ARB;
        rr_ptr_d = wrap_add(rr_ptr_q, 1);
        cnt_d    = '0;
      end
    end else if (req_lock[gnt_idx] && (MAX_BURST > 1)) begin
      state_d  = LOCKED;
      rr_ptr_d = gnt_idx;
      cnt_d    = CW'(1);
    end else begin
      state_d  = ARB;
      rr_ptr_d = wrap_add(gnt_idx, 1);
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      rs_valid_q   <= 1'b0;
      rs_x_q       <= '0;
      rs_y_q       <= '0;
      rs_owner_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      rs_valid_q   <= rs_valid_d;
      rs_x_q       <= rs_x_d;
      rs_y_q       <= rs_y_d;
      rs_owner_q   <= rs_owner_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Stage 0 loads alongside rs_valid so the last stage lines up with the result.
  intf_tag_pipe #(
    .LAT (LAT),
    .TW  (TW)
  ) u_tag_pipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (rs_valid_q),
    .in_owner   (rs_owner_q),
    .last_valid (last_valid),
    .last_owner (last_owner)
  );

  assign rsp_hit    = rs_xtwo_valid && last_valid;
  assign rsp_valid  = rsp_hit ? (NREQ'(1) << last_owner) : '0;
  assign rsp_xtwo   = rsp_hit ? rs_xtwo : '0;
  assign rs_valid   = rs_valid_q;
  assign rs_x       = rs_x_q;
  assign rs_y       = rs_y_q;
  assign err_orphan = err_orphan_q;

endmodule
`default_nettype wire
